mem_stage: RTL and testbench

- Pipeline MEM stage: sits between the EX and WB stages.
- Latches the packed EX result and drives the data-memory request/response handshake for loads and stores.
- Extracts and sign- or zero-extends load data, then forwards the writeback payload to WB.
- Returns a bypass/hazard record to ID.

---
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: latches the EX record, runs the data-memory handshake, extends load data, feeds WB.
// Latency: non-memory op 1 cycle to WB valid; store >= 2 cycles; load >= 3 cycles (plus memory stalls).
// Backpressure: MEM_ready drops while a record is in flight; a DONE record holds until WB_ready.
module mem_stage #(
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [181:0] EX_to_MEM_data,
  input  logic         EX_to_MEM_valid,
  output logic         MEM_ready,
  output logic [31:0]  Address,
  output logic         MemWrite,
  output logic [31:0]  Write_data,
  output logic [3:0]   Write_strb,
  output logic         MemRead,
  input  logic         Mem_Req_Ready,
  input  logic [31:0]  Read_data,
  input  logic         Read_data_Valid,
  output logic         Read_data_Ready,
  output logic [69:0]  MEM_to_WB_data,
  output logic         MEM_to_WB_valid,
  input  logic         WB_ready,
  output logic [38:0]  MEM_to_ID_bypath_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  // Cleared record except for the PC field, which starts at PC_RESET.
  localparam logic [181:0] REC_RESET = {74'd0, PC_RESET, 76'd0};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [181:0]  r_rec;
  logic [31:0]   r_rdata;

  logic [31:0]   w_result;
  logic [2:0]    w_func;
  logic [1:0]    w_eff;
  logic [31:0]   w_pc;
  logic [31:0]   w_addr;
  logic          w_load;
  logic          w_store;
  logic          w_wen;
  logic [4:0]    w_waddr;
  logic [31:0]   w_rf_wdata;
  logic          w_rf_wen;
  logic          w_accept;
  logic          w_in_mem;
  logic [7:0]    w_ld_byte;
  logic [15:0]   w_ld_half;
  logic [31:0]   w_ld_ext;
  logic          w_unused_rsvd;

  assign w_result = r_rec[181:150];
  assign w_func   = r_rec[149:147];
  assign w_eff    = r_rec[109:108];
  assign w_pc     = r_rec[107:76];
  assign w_addr   = r_rec[75:44];
  assign w_load   = r_rec[43];
  assign w_store  = r_rec[42];
  assign w_wen    = r_rec[5];
  assign w_waddr  = r_rec[4:0];

  // U_imm and opcode are reserved; byte offset is carried separately in eff.
  assign w_unused_rsvd = ^{r_rec[146:110], r_rec[45:44]};

  assign MEM_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && WB_ready);
  assign w_accept  = EX_to_MEM_valid && MEM_ready;
  assign w_in_mem  = EX_to_MEM_data[43] | EX_to_MEM_data[42];

  // Next-state: memory ops go through REQ, loads also wait in RESP for data.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_in_mem ? S_REQ : S_DONE;
      S_REQ:  if (Mem_Req_Ready) w_state_nxt = w_load ? S_RESP : S_DONE;
      S_RESP: if (Read_data_Valid) w_state_nxt = S_DONE;
      S_DONE: if (WB_ready) begin
        if (w_accept) w_state_nxt = w_in_mem ? S_REQ : S_DONE;
        else          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Record latch on accept; extracted load data captured on the response beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rec   <= REC_RESET;
      r_rdata <= 32'd0;
    end else begin
      if (w_accept) r_rec <= EX_to_MEM_data;
      if ((r_state == S_RESP) && Read_data_Valid) r_rdata <= w_ld_ext;
    end
  end

  // Byte/half selection by eff, then sign/zero extension by func.
  always_comb begin
    w_ld_byte = Read_data[7:0];
    case (w_eff)
      2'b01:   w_ld_byte = Read_data[15:8];
      2'b10:   w_ld_byte = Read_data[23:16];
      2'b11:   w_ld_byte = Read_data[31:24];
      default: w_ld_byte = Read_data[7:0];
    endcase
    w_ld_half = w_eff[1] ? Read_data[31:16] : Read_data[15:0];
    case (w_func)
      3'b000:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_ext = {24'd0, w_ld_byte};
      3'b001:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_ext = {16'd0, w_ld_half};
      default: w_ld_ext = Read_data;
    endcase
  end

  assign MemRead         = (r_state == S_REQ) && w_load;
  assign MemWrite        = (r_state == S_REQ) && w_store;
  assign Address         = {w_addr[31:2], 2'b00};
  assign Write_data      = r_rec[37:6];
  assign Write_strb      = r_rec[41:38];
  assign Read_data_Ready = (r_state == S_RESP);

  // Stores never write the register file, whatever the latched RF_wen says.
  assign w_rf_wen   = w_wen && !w_store;
  assign w_rf_wdata = w_load ? r_rdata : w_result;

  assign MEM_to_WB_valid = (r_state == S_DONE);
  assign MEM_to_WB_data  = {w_rf_wen, w_waddr, w_rf_wdata, w_pc};

  assign MEM_to_ID_bypath_data = {
    w_load && ((r_state == S_REQ) || (r_state == S_RESP)),
    (r_state != S_IDLE) && w_rf_wen && (w_waddr != 5'd0),
    w_waddr,
    w_rf_wdata
  };

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  localparam logic [31:0] PC_RST = 32'hABCD_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic [181:0] EX_to_MEM_data;
  logic         EX_to_MEM_valid;
  logic         MEM_ready;
  logic [31:0]  Address;
  logic         MemWrite;
  logic [31:0]  Write_data;
  logic [3:0]   Write_strb;
  logic         MemRead;
  logic         Mem_Req_Ready;
  logic [31:0]  Read_data;
  logic         Read_data_Valid;
  logic         Read_data_Ready;
  logic [69:0]  MEM_to_WB_data;
  logic         MEM_to_WB_valid;
  logic         WB_ready;
  logic [38:0]  MEM_to_ID_bypath_data;

  always #5 clk = ~clk;

  mem_stage #(.PC_RESET(PC_RST)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .EX_to_MEM_data        (EX_to_MEM_data),
    .EX_to_MEM_valid       (EX_to_MEM_valid),
    .MEM_ready             (MEM_ready),
    .Address               (Address),
    .MemWrite              (MemWrite),
    .Write_data            (Write_data),
    .Write_strb            (Write_strb),
    .MemRead               (MemRead),
    .Mem_Req_Ready         (Mem_Req_Ready),
    .Read_data             (Read_data),
    .Read_data_Valid       (Read_data_Valid),
    .Read_data_Ready       (Read_data_Ready),
    .MEM_to_WB_data        (MEM_to_WB_data),
    .MEM_to_WB_valid       (MEM_to_WB_valid),
    .WB_ready              (WB_ready),
    .MEM_to_ID_bypath_data (MEM_to_ID_bypath_data)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  func;
    logic [1:0]  eff;
    logic [31:0] addr;
    logic [31:0] res;
    logic [31:0] rdata;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] pc;
    logic [3:0]  strb;
    int          lat;
    logic [69:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [181:0] mk(input logic [31:0] res, input logic [2:0] func,
                                      input logic [1:0] eff, input logic [31:0] pc,
                                      input logic [31:0] addr, input logic ld, input logic st,
                                      input logic [3:0] strb, input logic [31:0] wdata,
                                      input logic wen, input logic [4:0] waddr);
    mk = {res, func, 32'd0, 5'd0, eff, pc, addr, ld, st, strb, wdata, wen, waddr};
  endfunction

  function automatic vec_t V(input logic ld, input logic st, input logic [2:0] func,
                             input logic [1:0] eff, input logic [31:0] addr,
                             input logic [31:0] res, input logic [31:0] rdata,
                             input logic wen, input logic [4:0] waddr, input logic [31:0] pc,
                             input logic [3:0] strb, input int lat, input logic [69:0] exp);
    V.ld = ld; V.st = st; V.func = func; V.eff = eff; V.addr = addr; V.res = res;
    V.rdata = rdata; V.wen = wen; V.waddr = waddr; V.pc = pc; V.strb = strb;
    V.lat = lat; V.exp = exp;
  endfunction

  // Drives one record with memory and WB always ready; checks latency and WB payload.
  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    bit  found;
    n = 0;
    found = 0;
    Read_data       = v.rdata;
    EX_to_MEM_data  = mk(v.res, v.func, v.eff, v.pc, v.addr, v.ld, v.st, v.strb, 32'd0, v.wen, v.waddr);
    EX_to_MEM_valid = 1'b1;
    @(posedge clk); #1;
    EX_to_MEM_valid = 1'b0;
    for (int c = 1; c <= 10 && !found; c++) begin
      @(negedge clk);
      if (MEM_to_WB_valid) begin
        found = 1;
        n = c;
      end
    end
    chk($sformatf("vec%0d_latency", idx), 70'(n), 70'(v.lat));
    chk($sformatf("vec%0d_wb_data", idx), MEM_to_WB_data, v.exp);
    @(negedge clk);
    chk($sformatf("vec%0d_idle", idx), 70'(MEM_to_WB_valid), 70'd0);
  endtask

  initial begin
    rst             = 1'b1;
    EX_to_MEM_data  = '0;
    EX_to_MEM_valid = 1'b0;
    Mem_Req_Ready   = 1'b0;
    Read_data       = 32'd0;
    Read_data_Valid = 1'b0;
    WB_ready        = 1'b1;

    //              ld st func    eff    addr        res         rdata        wen wa     pc          strb   lat exp
    vecs[0] = V(0, 0, 3'b000, 2'b00, 32'h0,     32'h10,     32'h0,        1, 5'd5,  32'h1000, 4'h0, 1, {1'b1, 5'd5,  32'h0000_0010, 32'h1000});
    vecs[1] = V(1, 0, 3'b000, 2'b11, 32'h100,   32'h0,      32'h80FF_0000, 1, 5'd7,  32'h1004, 4'h0, 3, {1'b1, 5'd7,  32'hFFFF_FF80, 32'h1004});
    vecs[2] = V(1, 0, 3'b101, 2'b10, 32'h104,   32'h0,      32'h9234_5678, 1, 5'd10, 32'h1008, 4'h0, 3, {1'b1, 5'd10, 32'h0000_9234, 32'h1008});
    vecs[3] = V(1, 0, 3'b001, 2'b10, 32'h104,   32'h0,      32'h9234_5678, 1, 5'd11, 32'h100C, 4'h0, 3, {1'b1, 5'd11, 32'hFFFF_9234, 32'h100C});
    vecs[4] = V(1, 0, 3'b100, 2'b01, 32'h108,   32'h0,      32'h1234_5678, 1, 5'd12, 32'h1010, 4'h0, 3, {1'b1, 5'd12, 32'h0000_0056, 32'h1010});
    vecs[5] = V(1, 0, 3'b010, 2'b00, 32'h10C,   32'h0,      32'hDEAD_BEEF, 1, 5'd13, 32'h1014, 4'h0, 3, {1'b1, 5'd13, 32'hDEAD_BEEF, 32'h1014});
    vecs[6] = V(1, 0, 3'b011, 2'b01, 32'h110,   32'h0,      32'hCAFE_F00D, 1, 5'd14, 32'h1018, 4'h0, 3, {1'b1, 5'd14, 32'hCAFE_F00D, 32'h1018});
    vecs[7] = V(0, 1, 3'b000, 2'b10, 32'h20,    32'h55,     32'h0,        1, 5'd9,  32'h101C, 4'h4, 2, {1'b0, 5'd9,  32'h0000_0055, 32'h101C});
    vecs[8] = V(1, 0, 3'b000, 2'b00, 32'h114,   32'h0,      32'h0000_007F, 1, 5'd15, 32'h1020, 4'h0, 3, {1'b1, 5'd15, 32'h0000_007F, 32'h1020});
    vecs[9] = V(1, 0, 3'b001, 2'b00, 32'h118,   32'h0,      32'h0000_8001, 1, 5'd16, 32'h1024, 4'h0, 3, {1'b1, 5'd16, 32'hFFFF_8001, 32'h1024});

    // Reset state
    #3;
    chk("rst_memread",  70'(MemRead), 70'd0);
    chk("rst_memwrite", 70'(MemWrite), 70'd0);
    chk("rst_rdready",  70'(Read_data_Ready), 70'd0);
    chk("rst_wbvalid",  70'(MEM_to_WB_valid), 70'd0);
    chk("rst_memready", 70'(MEM_ready), 70'd1);
    chk("rst_bypass",   70'(MEM_to_ID_bypath_data), 70'd0);
    chk("rst_wbdata",   MEM_to_WB_data, {1'b0, 5'd0, 32'd0, PC_RST});
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back ALU records, no bubble
    WB_ready = 1'b1;
    EX_to_MEM_data  = mk(32'h10, 3'b000, 2'b00, 32'h2000, 32'h0, 0, 0, 4'h0, 32'h0, 1, 5'd5);
    EX_to_MEM_valid = 1'b1;
    @(posedge clk); #1;
    EX_to_MEM_data  = mk(32'h20, 3'b000, 2'b00, 32'h2004, 32'h0, 0, 0, 4'h0, 32'h0, 1, 5'd6);
    @(negedge clk);
    chk("b2b_valid1",    70'(MEM_to_WB_valid), 70'd1);
    chk("b2b_data1",     MEM_to_WB_data, {1'b1, 5'd5, 32'h10, 32'h2000});
    chk("b2b_memready",  70'(MEM_ready), 70'd1);
    @(posedge clk); #1;
    EX_to_MEM_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid2",    70'(MEM_to_WB_valid), 70'd1);
    chk("b2b_data2",     MEM_to_WB_data, {1'b1, 5'd6, 32'h20, 32'h2004});
    @(negedge clk);
    chk("b2b_idle",      70'(MEM_to_WB_valid), 70'd0);

    // LB with the memory request stalled for 3 cycles
    Mem_Req_Ready   = 1'b0;
    Read_data_Valid = 1'b0;
    EX_to_MEM_data  = mk(32'h0, 3'b000, 2'b11, 32'h3000, 32'h100, 1, 0, 4'h0, 32'h0, 1, 5'd7);
    EX_to_MEM_valid = 1'b1;
    @(posedge clk); #1;
    EX_to_MEM_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("lb_stall%0d_memread", i), 70'(MemRead), 70'd1);
      chk($sformatf("lb_stall%0d_addr", i),    70'(Address), 70'h100);
      chk($sformatf("lb_stall%0d_busy", i),    70'(MEM_to_ID_bypath_data[38]), 70'd1);
    end
    Mem_Req_Ready = 1'b1;
    @(posedge clk); #1;
    Mem_Req_Ready   = 1'b0;
    Read_data       = 32'h80FF_0000;
    Read_data_Valid = 1'b1;
    @(negedge clk);
    chk("lb_resp_memread", 70'(MemRead), 70'd0);
    chk("lb_resp_rdready", 70'(Read_data_Ready), 70'd1);
    chk("lb_resp_busy",    70'(MEM_to_ID_bypath_data[38]), 70'd1);
    @(posedge clk); #1;
    Read_data_Valid = 1'b0;
    @(negedge clk);
    chk("lb_done_valid",  70'(MEM_to_WB_valid), 70'd1);
    chk("lb_done_data",   MEM_to_WB_data, {1'b1, 5'd7, 32'hFFFF_FF80, 32'h3000});
    chk("lb_done_bypass", 70'(MEM_to_ID_bypath_data), 70'({1'b0, 1'b1, 5'd7, 32'hFFFF_FF80}));
    @(negedge clk);
    chk("lb_idle", 70'(MEM_to_WB_valid), 70'd0);

    // SB: single-cycle MemWrite, no response handshake, RF_wen forced low
    Mem_Req_Ready   = 1'b1;
    Read_data_Valid = 1'b0;
    EX_to_MEM_data  = mk(32'h77, 3'b000, 2'b10, 32'h4000, 32'h206, 0, 1, 4'b0100, 32'h00AB_0000, 1, 5'd9);
    EX_to_MEM_valid = 1'b1;
    @(posedge clk); #1;
    EX_to_MEM_valid = 1'b0;
    @(negedge clk);
    chk("sb_memwrite",  70'(MemWrite), 70'd1);
    chk("sb_memread",   70'(MemRead), 70'd0);
    chk("sb_strb",      70'(Write_strb), 70'(4'b0100));
    chk("sb_wdata",     70'(Write_data), 70'h00AB_0000);
    chk("sb_addr",      70'(Address), 70'h204);
    chk("sb_rdready1",  70'(Read_data_Ready), 70'd0);
    @(negedge clk);
    chk("sb_memwrite_off", 70'(MemWrite), 70'd0);
    chk("sb_rdready2",     70'(Read_data_Ready), 70'd0);
    chk("sb_wbvalid",      70'(MEM_to_WB_valid), 70'd1);
    chk("sb_wbdata",       MEM_to_WB_data, {1'b0, 5'd9, 32'h77, 32'h4000});
    chk("sb_bypass_write", 70'(MEM_to_ID_bypath_data[37]), 70'd0);
    @(negedge clk);
    chk("sb_idle", 70'(MEM_to_WB_valid), 70'd0);

    // WB stall: DONE held, next EX record not latched until WB_ready
    WB_ready = 1'b0;
    EX_to_MEM_data  = mk(32'h111, 3'b000, 2'b00, 32'h5000, 32'h0, 0, 0, 4'h0, 32'h0, 1, 5'd3);
    EX_to_MEM_valid = 1'b1;
    @(posedge clk); #1;
    EX_to_MEM_data  = mk(32'h222, 3'b000, 2'b00, 32'h5004, 32'h0, 0, 0, 4'h0, 32'h0, 1, 5'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i),    70'(MEM_to_WB_valid), 70'd1);
      chk($sformatf("stall%0d_data", i),     MEM_to_WB_data, {1'b1, 5'd3, 32'h111, 32'h5000});
      chk($sformatf("stall%0d_memready", i), 70'(MEM_ready), 70'd0);
    end
    WB_ready = 1'b1;
    @(posedge clk); #1;
    EX_to_MEM_valid = 1'b0;
    @(negedge clk);
    chk("stall_next_valid", 70'(MEM_to_WB_valid), 70'd1);
    chk("stall_next_data",  MEM_to_WB_data, {1'b1, 5'd4, 32'h222, 32'h5004});
    @(negedge clk);
    chk("stall_idle", 70'(MEM_to_WB_valid), 70'd0);

    // Asynchronous reset while waiting for a load response
    Mem_Req_Ready   = 1'b1;
    Read_data_Valid = 1'b0;
    EX_to_MEM_data  = mk(32'h0, 3'b010, 2'b00, 32'h6000, 32'h300, 1, 0, 4'h0, 32'h0, 1, 5'd8);
    EX_to_MEM_valid = 1'b1;
    @(posedge clk); #1;
    EX_to_MEM_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("arst_in_resp", 70'(Read_data_Ready), 70'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rdready",  70'(Read_data_Ready), 70'd0);
    chk("arst_memread",  70'(MemRead), 70'd0);
    chk("arst_wbvalid",  70'(MEM_to_WB_valid), 70'd0);
    chk("arst_memready", 70'(MEM_ready), 70'd1);
    chk("arst_bypass",   70'(MEM_to_ID_bypath_data), 70'd0);
    chk("arst_wbdata",   MEM_to_WB_data, {1'b0, 5'd0, 32'd0, PC_RST});
    @(negedge clk);
    rst             = 1'b0;
    Read_data       = 32'h1234_5678;
    Read_data_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("late_resp%0d_wbvalid", i), 70'(MEM_to_WB_valid), 70'd0);
      chk($sformatf("late_resp%0d_rdready", i), 70'(Read_data_Ready), 70'd0);
    end

    // Table-driven vectors with memory and WB always ready
    Mem_Req_Ready   = 1'b1;
    Read_data_Valid = 1'b1;
    WB_ready        = 1'b1;
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
